// File: rtl/rr_arbiter4.sv
// rr_arbiter4 - four-requester round-robin arbiter for a shared 4:1 datapath mux.
// Picks one requester, drives a one-hot grant and the mux select, and holds
// the grant until the shared resource reports completion. Priority rotates so
// that the requester after the last one served is scanned first.
//
// Optional feature macro: ARB_TIMEOUT_EN (forced release after MAX_HOLD busy cycles).
//
// Ports:
//   clk_i      rising-edge clock
//   rst_i      synchronous active-high reset
//   req_i      request per requester (bit n = requester n)
//   done_i     shared resource finished the current transaction (used only while busy)
//   grant_o    registered one-hot grant, zero when idle
//   sel_o      registered mux select for the granted requester
//   valid_o    transaction active toward the shared resource
//   ack_o      combinational completion strobe, grant_o & {4{done_i}}
//   busy_o     arbiter is in the busy state
//   timeout_o  one-cycle forced-release pulse (constant 0 without ARB_TIMEOUT_EN)
module rr_arbiter4 #(
  parameter int unsigned SEL_INVERT = 0,
  parameter int unsigned MAX_HOLD   = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] req_i,
  input  logic       done_i,
  output logic [3:0] grant_o,
  output logic [1:0] sel_o,
  output logic       valid_o,
  output logic [3:0] ack_o,
  output logic       busy_o,
  output logic       timeout_o
);

  if (MAX_HOLD == 0) begin : g_bad_max_hold
    $error("rr_arbiter4: MAX_HOLD must be >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [1:0] idx, idx_nxt;
  logic [3:0] grant_nxt;
  logic [1:0] sel_nxt;
  logic [1:0] pick;
  logic       pick_ok;
  logic       expire;

  // First requester at or after ptr, wrapping modulo 4.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!pick_ok && req_i[ptr + 2'(k)]) begin
        pick    = ptr + 2'(k);
        pick_ok = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(MAX_HOLD + 1);

  logic [CW-1:0] hold_cnt;
  logic          timeout_q;

  assign expire = (hold_cnt == CW'(MAX_HOLD - 1));

  // Cleared throughout IDLE, so it starts at zero on the first busy cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= (state == BUSY) && !done_i && expire;
      if (state == IDLE) begin
        hold_cnt <= '0;
      end else if (!done_i) begin
        hold_cnt <= hold_cnt + CW'(1);
      end
    end
  end

  assign timeout_o = timeout_q;
`else
  assign expire    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = idx;
    grant_nxt = grant_o;
    sel_nxt   = sel_o;
    unique case (state)
      IDLE: begin
        if (pick_ok) begin
          state_nxt = BUSY;
          idx_nxt   = pick;
          grant_nxt = 4'b0001 << pick;
          sel_nxt   = (SEL_INVERT != 0) ? 2'd3 - pick : pick;
        end
      end
      BUSY: begin
        // done_i and expiry release identically; only timeout_o differs.
        if (done_i || expire) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          ptr_nxt   = idx + 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      ptr     <= '0;
      idx     <= '0;
      grant_o <= '0;
      sel_o   <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      idx     <= idx_nxt;
      grant_o <= grant_nxt;
      sel_o   <= sel_nxt;
    end
  end

  assign valid_o = (state == BUSY);
  assign busy_o  = (state == BUSY);
  assign ack_o   = grant_o & {4{done_i}};

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4 - self-checking bench for rr_arbiter4.
// Two instances share the same stimulus: one with a direct select and one
// with an inverted select, both with MAX_HOLD = 4. A table of directed
// vectors and hand-written sequences come first, followed by random
// stimulus checked against a behavioural model of the arbitration rules.
module tb_rr_arbiter4;

  localparam int unsigned HOLD = 4;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic       valid;
    logic [3:0] ack;
    logic       tmo;
    logic [1:0] sel;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] req_i = '0;
  logic       done_i = 1'b0;

  logic [3:0] grant_a, grant_b, ack_a, ack_b;
  logic [1:0] sel_a, sel_b;
  logic       valid_a, valid_b, busy_a, busy_b, tmo_a, tmo_b;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit m_busy = 1'b0;
  bit m_to   = 1'b0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_cnt   = 0;
  bit tmo_en;

  always #5 clk = ~clk;

  rr_arbiter4 #(.SEL_INVERT(0), .MAX_HOLD(HOLD)) dut_a (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .done_i(done_i),
    .grant_o(grant_a), .sel_o(sel_a), .valid_o(valid_a), .ack_o(ack_a),
    .busy_o(busy_a), .timeout_o(tmo_a)
  );

  rr_arbiter4 #(.SEL_INVERT(1), .MAX_HOLD(HOLD)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .done_i(done_i),
    .grant_o(grant_b), .sel_o(sel_b), .valid_o(valid_b), .ack_o(ack_b),
    .busy_o(busy_b), .timeout_o(tmo_b)
  );

  function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic done,
                              input logic [3:0] grant, input logic valid,
                              input logic [3:0] ack, input logic tmo, input logic [1:0] sel);
    vec_t v;
    v.rst = rst; v.req = req; v.done = done;
    v.grant = grant; v.valid = valid; v.ack = ack; v.tmo = tmo; v.sel = sel;
    return v;
  endfunction

  task automatic chk(input string name, input int n, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  // Round-robin rules: release moves priority just past the owner; a grant
  // goes to the first requester found scanning from the priority pointer.
  task automatic model_update(input vec_t v);
    if (v.rst) begin
      m_busy = 0; m_ptr = 0; m_cnt = 0; m_to = 0;
    end else if (!m_busy) begin
      m_to = 0;
      for (int k = 0; k < 4; k++) begin
        if (!m_busy && v.req[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_busy  = 1;
          m_cnt   = 0;
        end
      end
    end else if (v.done) begin
      m_busy = 0; m_ptr = (m_owner + 1) % 4; m_to = 0;
    end else if (tmo_en && m_cnt == HOLD - 1) begin
      m_busy = 0; m_ptr = (m_owner + 1) % 4; m_to = 1;
    end else begin
      m_cnt++; m_to = 0;
    end
  endtask

  task automatic step(input vec_t v, input int n);
    rst_i  = v.rst;
    req_i  = v.req;
    done_i = v.done;
    @(negedge clk);
    chk("grant", n, grant_a, v.grant);
    chk("grant_inv", n, grant_b, v.grant);
    chk("valid", n, 4'(valid_a), 4'(v.valid));
    chk("busy", n, 4'(busy_a), 4'(v.valid));
    chk("ack", n, ack_a, v.ack);
    chk("ack_inv", n, ack_b, v.ack);
    chk("timeout", n, 4'(tmo_a), 4'(v.tmo));
    chk("timeout_inv", n, 4'(tmo_b), 4'(v.tmo));
    if (v.valid) begin
      chk("sel", n, 4'(sel_a), 4'(v.sel));
      chk("sel_inv", n, 4'(sel_b), 4'(2'd3 - v.sel));
    end
    @(posedge clk);
    model_update(v);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
`ifdef ARB_TIMEOUT_EN
    tmo_en = 1'b1;
`else
    tmo_en = 1'b0;
`endif
    //                rst req      done grant    vld ack      to  sel
    // reset with everything asserted, then release
    tbl.push_back(mk(1, 4'b1111, 1, 4'b0000, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 4'b1111, 1, 4'b0000, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 0));
    // single requester 1, done in cycle 3, regrant in cycle 5
    tbl.push_back(mk(0, 4'b0010, 0, 4'b0000, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 0, 4'b0010, 1, 4'b0000, 0, 1));
    tbl.push_back(mk(0, 4'b0010, 0, 4'b0010, 1, 4'b0000, 0, 1));
    tbl.push_back(mk(0, 4'b0010, 1, 4'b0010, 1, 4'b0010, 0, 1));
    tbl.push_back(mk(0, 4'b0010, 0, 4'b0000, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 0, 4'b0010, 1, 4'b0000, 0, 1));
    tbl.push_back(mk(0, 4'b0010, 1, 4'b0010, 1, 4'b0010, 0, 1));
    // reset back to ptr 0, then fairness with all four requesting
    tbl.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 0, 4'b0000, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, 1, 4'b0001, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 0, 4'b0000, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0010, 1, 4'b0010, 0, 1));
    tbl.push_back(mk(0, 4'b1111, 0, 4'b0000, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0100, 1, 4'b0100, 0, 2));
    tbl.push_back(mk(0, 4'b1111, 0, 4'b0000, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b1000, 1, 4'b1000, 0, 3));
    // wrap to requester 0, then drop its request while busy
    tbl.push_back(mk(0, 4'b1001, 0, 4'b0000, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b1001, 0, 4'b0001, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b1000, 0, 4'b0001, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0001, 1, 4'b0000, 0, 0));
    // done in the 4th busy cycle: normal ack, never a timeout
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0001, 1, 4'b0001, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 0));
    // done while idle is ignored
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 0));

    // first edge with reset asserted
    rst_i = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // Priority pointer is now 1.
`ifdef ARB_TIMEOUT_EN
    step(mk(0, 4'b0100, 0, 4'b0000, 0, 4'b0000, 0, 0), 100);
    for (int i = 0; i < 4; i++) step(mk(0, 4'b0100, 0, 4'b0100, 1, 4'b0000, 0, 2), 101 + i);
    step(mk(0, 4'b0101, 0, 4'b0000, 0, 4'b0000, 1, 0), 105);
    for (int i = 0; i < 3; i++) step(mk(0, 4'b0101, 0, 4'b0001, 1, 4'b0000, 0, 0), 106 + i);
    step(mk(0, 4'b0101, 1, 4'b0001, 1, 4'b0001, 0, 0), 109);
    step(mk(0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 0), 110);
`else
    step(mk(0, 4'b0100, 0, 4'b0000, 0, 4'b0000, 0, 0), 100);
    for (int i = 0; i < 8; i++) step(mk(0, 4'b0100, 0, 4'b0100, 1, 4'b0000, 0, 2), 101 + i);
    step(mk(0, 4'b0101, 1, 4'b0100, 1, 4'b0100, 0, 2), 109);
    step(mk(0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 0), 110);
`endif

    // reset in the middle of a grant aborts it silently
    step(mk(0, 4'b0010, 0, 4'b0000, 0, 4'b0000, 0, 0), 200);
    step(mk(0, 4'b0010, 0, 4'b0010, 1, 4'b0000, 0, 1), 201);
    step(mk(1, 4'b0010, 0, 4'b0010, 1, 4'b0000, 0, 1), 202);
    step(mk(0, 4'b1111, 1, 4'b0000, 0, 4'b0000, 0, 0), 203);
    step(mk(0, 4'b1111, 0, 4'b0001, 1, 4'b0000, 0, 0), 204);
    step(mk(0, 4'b1111, 1, 4'b0001, 1, 4'b0001, 0, 0), 205);
    step(mk(0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 0), 206);

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      v.rst   = ($urandom_range(0, 59) == 0);
      v.req   = 4'($urandom);
      v.done  = ($urandom_range(0, 4) == 0);
      v.grant = m_busy ? 4'(1 << m_owner) : 4'b0000;
      v.valid = m_busy;
      v.ack   = v.done ? v.grant : 4'b0000;
      v.tmo   = m_to;
      v.sel   = 2'(m_owner);
      step(v, 1000 + i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter/sequencer for a shared 4:1 datapath mux, e.g. one memory/bus port shared by fetch, load/store, debug and DMA requesters.
- Picks one requester and drives the mux select plus a one-hot grant.
- Holds the grant for the whole transaction until the shared resource signals completion.
- Advances priority so no requester starves.

Parameters:
- SEL_INVERT, 0, 0: sel_o = granted index; 1: sel_o = 3 - index (for mux channel orderings reversed w.r.t. requester index).
- MAX_HOLD, 16, maximum BUSY cycles per grant before forced release; only used with ARB_TIMEOUT_EN; must be >= 1.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous reset, active-high.
- req_i  input  4  request per requester; bit n = requester n.
- done_i  input  1  shared resource completed current transaction; sampled only in BUSY.
- grant_o  output  4  one-hot registered grant; all-zero when idle.
- sel_o  output  2  registered mux select for the granted requester.
- valid_o  output  1  transaction active toward shared resource (= BUSY).
- ack_o  output  4  completion strobe: grant_o & {4{done_i}}, combinational.
- busy_o  output  1  state == BUSY.
- timeout_o  output  1  one-cycle forced-release pulse; tied 0 when feature disabled.

Behaviour:
- Reset (rst_i high at clock edge):
  - state = IDLE, ptr = 0, hold_cnt = 0.
  - grant_o = 0, sel_o = 0, valid_o = 0, busy_o = 0, timeout_o = 0.
  - ack_o = 0, since grant_o = 0.
  - Reset mid-BUSY aborts silently: no ack, no timeout.
- States: IDLE, BUSY.
- IDLE:
  - If req_i != 0, select the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Register grant_o, sel_o and valid_o = 1; go to BUSY next cycle.
  - Latency: request seen at edge t → grant visible in cycle t+1.
  - If req_i == 0, stay in IDLE.
  - done_i is ignored in IDLE.
- BUSY:
  - Grant is frozen regardless of req_i; dropping req_i does not release it.
  - On done_i = 1: ack_o strobes in the same cycle. Next cycle: IDLE, grant_o = 0, valid_o = 0, ptr = granted index + 1 (mod 4, wraps 3 → 0).
  - Minimum one IDLE cycle between grants, so back-to-back grants are 1 cycle apart at best. Earliest next grant is 2 cycles after the done cycle.
- ptr changes only on grant release (done or timeout).
- sel_o always matches grant_o while busy; it holds its last value while idle (don't-care, but must be stable).
- Grant invariant: grant_o is never multi-hot, and grant_o != 0 iff busy_o.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Enabled:
  - hold_cnt ($clog2(MAX_HOLD+1) bits) clears on grant and increments each BUSY cycle without done_i.
  - If hold_cnt == MAX_HOLD-1 and done_i == 0: force IDLE next cycle, no ack, timeout_o = 1 for exactly that next cycle, ptr advances as on done.
  - The grant therefore lasts exactly MAX_HOLD cycles.
  - done_i in the final cycle wins: normal ack, no timeout.
- Disabled: no counter, timeout_o constant 0, BUSY held indefinitely until done_i.

Test Plan:
- Reset: assert rst_i 2 cycles with req_i = 1111 and done_i = 1 → grant_o = 0000, valid_o = 0, ack_o = 0000, timeout_o = 0 throughout and on the first cycle after release.
- Single requester: req_i = 0010 from cycle 0; done_i = 1 in cycle 3 → grant_o = 0010, sel_o = 1, valid_o = 1 in cycles 1–3; ack_o = 0010 in cycle 3 only; grant_o = 0000 in cycle 4; regrant 0010 in cycle 5.
- Fairness: req_i = 1111 held; done_i pulsed on the first BUSY cycle of each grant → grant sequence 0001, 0010, 0100, 1000, 0001, each separated by one idle cycle.
- Wrap and dropped request: after serving requester 3, req_i = 1001 → grant 0001, sel_o = 0. Then deassert req_i[0] while BUSY → grant_o stays 0001 until done_i.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD = 4): req_i = 0100, done_i = 0 → grant_o = 0100 for exactly 4 cycles, then timeout_o = 1 for one cycle, no ack. With req_i = 0101 the next grant is 0001. Repeat with done_i = 1 in the 4th cycle → ack, no timeout.
- SEL_INVERT = 1 plus reset mid-BUSY: grant 0010 → sel_o = 2. Assert rst_i while BUSY → next cycle all outputs 0 and ptr = 0, so req_i = 1111 then grants 0001 first.
